// File: rtl/sdspi_bus_pkg.sv
// Shared types and pad levels for the SD-card SPI owner switch.
// Holds the switch FSM state enum plus park and reset pad constants.
package sdspi_bus_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    PARK   = 2'd2
  } bus_state_t;

  localparam logic PARK_CS   = 1'b1;
  localparam logic PARK_SCLK = 1'b0;
  localparam logic PARK_MOSI = 1'b1;

  localparam logic RST_SD_RESET = 1'b0;
  localparam logic RST_SD_DAT_1 = 1'b1;
  localparam logic RST_SD_DAT_2 = 1'b1;

endpackage

// File: rtl/sdspi_bus_guard_cnt.sv
// Loadable non-wrapping down-counter; done marks the last counted cycle.
// Used for the park guard interval and the optional drain timeout.
module sdspi_bus_guard_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/sdspi_bus_switch.sv
// Glitch-free N-way owner switch for the shared SD SPI pads.
// Optional drain timeout: define SDSPI_BUS_SWITCH_TIMEOUT_EN.
module sdspi_bus_switch
  import sdspi_bus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int SEL_W          = $clog2(N_MASTERS),
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [N_MASTERS-1:0] m_cs_i,
  input  logic [N_MASTERS-1:0] m_sclk_i,
  input  logic [N_MASTERS-1:0] m_mosi_i,
  input  logic [N_MASTERS-1:0] m_sd_reset_i,
  input  logic [N_MASTERS-1:0] m_dat1_i,
  input  logic [N_MASTERS-1:0] m_dat2_i,
  output logic [N_MASTERS-1:0] m_miso_o,
  input  logic                 miso,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 SD_RESET,
  output logic                 SD_DAT_1,
  output logic                 SD_DAT_2,
  output logic [SEL_W-1:0]     owner_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  bus_state_t       state_q;
  logic [SEL_W-1:0] target_q;
  logic             timeout_q;

  logic req;
  logic cs_rel;
  logic to_hit;
  logic guard_done;

  assign req = (sel_i != owner_o) &&
               (int'(sel_i) < N_MASTERS);
  assign cs_rel = m_cs_i[owner_o];

  sdspi_bus_guard_cnt #(
    .W(8)
  ) u_guard (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == DRAIN) && (cs_rel || to_hit)),
    .en       (state_q == PARK),
    .load_val (8'(GUARD_CYCLES)),
    .done     (guard_done)
  );

`ifdef SDSPI_BUS_SWITCH_TIMEOUT_EN
  logic to_done;

  sdspi_bus_guard_cnt #(
    .W(16)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == ACTIVE) && req),
    .en       (state_q == DRAIN),
    .load_val (16'(TIMEOUT_CYCLES)),
    .done     (to_done)
  );

  assign to_hit = to_done;
`else
  assign to_hit = 1'b0;
`endif

  // Pads are parked on the same edge PARK is entered, never a cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACTIVE;
      owner_o   <= '0;
      target_q  <= '0;
      timeout_q <= 1'b0;
      cs        <= PARK_CS;
      sclk      <= PARK_SCLK;
      mosi      <= PARK_MOSI;
      SD_RESET  <= RST_SD_RESET;
      SD_DAT_1  <= RST_SD_DAT_1;
      SD_DAT_2  <= RST_SD_DAT_2;
    end else begin
      unique case (state_q)
        ACTIVE: begin
          cs       <= m_cs_i[owner_o];
          sclk     <= m_sclk_i[owner_o];
          mosi     <= m_mosi_i[owner_o];
          SD_RESET <= m_sd_reset_i[owner_o];
          SD_DAT_1 <= m_dat1_i[owner_o];
          SD_DAT_2 <= m_dat2_i[owner_o];
          if (req) begin
            state_q  <= DRAIN;
            target_q <= sel_i;
          end
        end
        DRAIN: begin
          if (cs_rel || to_hit) begin
            state_q <= PARK;
            cs      <= PARK_CS;
            sclk    <= PARK_SCLK;
            mosi    <= PARK_MOSI;
            if (!cs_rel) timeout_q <= 1'b1;
          end else begin
            cs       <= m_cs_i[owner_o];
            sclk     <= m_sclk_i[owner_o];
            mosi     <= m_mosi_i[owner_o];
            SD_RESET <= m_sd_reset_i[owner_o];
            SD_DAT_1 <= m_dat1_i[owner_o];
            SD_DAT_2 <= m_dat2_i[owner_o];
          end
        end
        PARK: begin
          cs   <= PARK_CS;
          sclk <= PARK_SCLK;
          mosi <= PARK_MOSI;
          if (guard_done) begin
            state_q <= ACTIVE;
            owner_o <= target_q;
          end
        end
        default: state_q <= ACTIVE;
      endcase
    end
  end

  always_comb begin
    m_miso_o = '1;
    if (state_q == ACTIVE) m_miso_o[owner_o] = miso;
  end

  assign busy_o    = (state_q != ACTIVE);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sdspi_bus_switch.sv
// Directed self-checking bench for sdspi_bus_switch (3 masters, guard 8).
// Timeout scenario runs only when SDSPI_BUS_SWITCH_TIMEOUT_EN is defined.
module tb_sdspi_bus_switch;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sel;
  logic [N-1:0] m_cs, m_sclk, m_mosi;
  logic [N-1:0] m_sd_reset, m_dat1, m_dat2;
  logic [N-1:0] m_miso;
  logic         miso;
  logic         cs, sclk, mosi;
  logic         sd_reset, sd_dat1, sd_dat2;
  logic [1:0]   owner;
  logic         busy, timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdspi_bus_switch #(
    .N_MASTERS      (N),
    .GUARD_CYCLES   (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_i        (sel),
    .m_cs_i       (m_cs),
    .m_sclk_i     (m_sclk),
    .m_mosi_i     (m_mosi),
    .m_sd_reset_i (m_sd_reset),
    .m_dat1_i     (m_dat1),
    .m_dat2_i     (m_dat2),
    .m_miso_o     (m_miso),
    .miso         (miso),
    .cs           (cs),
    .sclk         (sclk),
    .mosi         (mosi),
    .SD_RESET     (sd_reset),
    .SD_DAT_1     (sd_dat1),
    .SD_DAT_2     (sd_dat2),
    .owner_o      (owner),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({owner, busy, timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0000",
               {owner, busy, timeout});
    end
    checks++;
    if ({cs, sclk, mosi, sd_reset, sd_dat1, sd_dat2} !== 6'b101011) begin
      failures++;
      $display("FAIL reset_pads got=%b exp=101011",
               {cs, sclk, mosi, sd_reset, sd_dat1, sd_dat2});
    end
    rst = 1'b0;
  endtask

  task automatic test_follow();
    m_cs = 3'b110;
    m_mosi = 3'b110;
    m_sd_reset = 3'b001;
    for (int i = 0; i < 6; i++) begin
      m_sclk[0] = i[0];
      m_sclk[1] = ~i[0];
      tick();
      checks++;
      if ({cs, sclk, mosi, sd_reset, owner, busy} !==
          {1'b0, i[0], 1'b0, 1'b1, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL follow_m0 i=%0d got=%b exp=%b", i,
                 {cs, sclk, mosi, sd_reset, owner, busy},
                 {1'b0, i[0], 1'b0, 1'b1, 2'd0, 1'b0});
      end
    end
    miso = 1'b0;
    #1;
    checks++;
    if (m_miso !== 3'b110) begin
      failures++;
      $display("FAIL miso_route got=%b exp=110", m_miso);
    end
    miso = 1'b1;
  endtask

  task automatic test_switch();
    m_cs = 3'b101;
    m_sclk = 3'b001;
    m_mosi = 3'b110;
    m_sd_reset = 3'b001;
    sel = 2'd1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) m_sd_reset = 3'b000;
      if (i == 1) begin
        checks++;
        if ({busy, cs, sclk, mosi} !== 4'b1110) begin
          failures++;
          $display("FAIL sw_drain got=%b exp=1110",
                   {busy, cs, sclk, mosi});
        end
      end else if (i <= 9) begin
        checks++;
        if ({busy, cs, sclk, mosi, sd_reset, owner} !== 7'b1101100) begin
          failures++;
          $display("FAIL sw_park i=%0d got=%b exp=1101100", i,
                   {busy, cs, sclk, mosi, sd_reset, owner});
        end
      end else begin
        checks++;
        if ({busy, owner, cs} !== 4'b0011) begin
          failures++;
          $display("FAIL sw_done got=%b exp=0011", {busy, owner, cs});
        end
      end
      if (i == 5) begin
        miso = 1'b0;
        #1;
        checks++;
        if (m_miso !== 3'b111) begin
          failures++;
          $display("FAIL miso_busy got=%b exp=111", m_miso);
        end
        miso = 1'b1;
      end
    end
    miso = 1'b0;
    tick();
    checks++;
    if ({cs, sd_reset, m_miso} !== 5'b00101) begin
      failures++;
      $display("FAIL sw_new_owner got=%b exp=00101", {cs, sd_reset, m_miso});
    end
    miso = 1'b1;
  endtask

  task automatic test_drain();
    int n;
`ifdef SDSPI_BUS_SWITCH_TIMEOUT_EN
    n = 15;
`else
    n = 50;
`endif
    m_cs = 3'b101;
    sel = 2'd0;
    tick();
    for (int i = 0; i < n; i++) begin
      m_sclk[1] = i[0];
      tick();
      checks++;
      if ({busy, cs, sclk, owner} !== {1'b1, 1'b0, i[0], 2'd1}) begin
        failures++;
        $display("FAIL drain_hold i=%0d got=%b exp=%b", i,
                 {busy, cs, sclk, owner}, {1'b1, 1'b0, i[0], 2'd1});
      end
    end
    m_sclk[1] = 1'b1;
    m_cs = 3'b111;
    tick();
    checks++;
    if ({busy, cs, sclk, mosi} !== 4'b1101) begin
      failures++;
      $display("FAIL drain_to_park got=%b exp=1101", {busy, cs, sclk, mosi});
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({busy, owner} !== 3'b101) begin
      failures++;
      $display("FAIL drain_guard got=%b exp=101", {busy, owner});
    end
    tick();
    checks++;
    if ({busy, owner} !== 3'b000) begin
      failures++;
      $display("FAIL drain_done got=%b exp=000", {busy, owner});
    end
  endtask

  task automatic test_back_to_back();
    m_cs = 3'b111;
    sel = 2'd1;
    tick();
    tick();
    sel = 2'd2;
    for (int i = 3; i <= 9; i++) tick();
    checks++;
    if ({busy, owner} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_first_park got=%b exp=100", {busy, owner});
    end
    tick();
    checks++;
    if ({busy, owner} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=001", {busy, owner});
    end
    for (int i = 11; i <= 19; i++) begin
      tick();
      checks++;
      if ({busy, owner} !== 3'b101) begin
        failures++;
        $display("FAIL b2b_second_busy i=%0d got=%b exp=101", i,
                 {busy, owner});
      end
    end
    tick();
    checks++;
    if ({busy, owner} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_second got=%b exp=010", {busy, owner});
    end
  endtask

  task automatic test_ignore_and_abort();
    sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, owner} !== 3'b010) begin
        failures++;
        $display("FAIL sel_oob i=%0d got=%b exp=010", i, {busy, owner});
      end
    end
    sel = 2'd0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, owner, cs} !== 4'b0001) begin
      failures++;
      $display("FAIL rst_abort got=%b exp=0001", {busy, owner, cs});
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, owner} !== 3'b000) begin
      failures++;
      $display("FAIL rst_target got=%b exp=000", {busy, owner});
    end
  endtask

  task automatic test_timeout();
`ifdef SDSPI_BUS_SWITCH_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cs = 3'b110;
    sel = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({busy, cs, timeout} !== 3'b100) begin
        failures++;
        $display("FAIL to_drain k=%0d got=%b exp=100", k,
                 {busy, cs, timeout});
      end
    end
    tick();
    checks++;
    if ({busy, cs, timeout} !== 3'b111) begin
      failures++;
      $display("FAIL to_fire got=%b exp=111", {busy, cs, timeout});
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({busy, owner, timeout} !== 4'b0011) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=0011", {busy, owner, timeout});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_clear got=%b exp=0", timeout);
    end
`else
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_tied got=%b exp=0", timeout);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    sel = 2'd0;
    m_cs = 3'b111;
    m_sclk = 3'b000;
    m_mosi = 3'b111;
    m_sd_reset = 3'b000;
    m_dat1 = 3'b111;
    m_dat2 = 3'b111;
    miso = 1'b1;
    test_reset();
    test_follow();
    test_switch();
    test_drain();
    test_back_to_back();
    test_ignore_and_abort();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
